// File: rtl/inst_fetch_buffer_pkg.sv
// Shared sizing defaults for the instruction fetch buffer slice.
// Mirrors the defines.v entries `Inst_Width, `Fetch_Buf_Depth and `Fetch_Buf_Ptr_Width.
package inst_fetch_buffer_pkg;

  localparam int unsigned FB_ADDR_W = 32;
  localparam int unsigned FB_INST_W = 32;
  localparam int unsigned FB_DEPTH  = 4;
  localparam int unsigned FB_PTR_W  = 3;

endpackage

// File: rtl/inst_fetch_buffer_mem.sv
// Fetch buffer storage: DEPTH x DATA_W register array, one write port, one async read port.
// No reset; contents are qualified by the pointers in the parent.
module fetch_buf_mem
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_DEPTH,
  parameter int unsigned DATA_W = FB_ADDR_W + FB_INST_W,
  parameter int unsigned IDX_W  = FB_PTR_W - 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer between PC/I-cache and Decoder: circular FIFO of {pc, inst}.
// Optional zero-latency empty-buffer bypass enabled by defining FETCH_BUF_BYPASS_EN.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_DEPTH,
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned INST_W = FB_INST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_vld,
  input  logic [ADDR_W-1:0]        fetch_pc,
  input  logic [INST_W-1:0]        fetch_inst,
  output logic                     fb_stall,
  output logic                     dec_vld,
  input  logic                     dec_rdy,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic [INST_W-1:0]        dec_inst,
  output logic [$clog2(DEPTH):0]   fb_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned DATA_W = ADDR_W + INST_W;

  logic [IDX_W:0]    rd_ptr, wr_ptr;
  logic              empty, full, push, pop, bypass;
  logic [DATA_W-1:0] rd_data;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

`ifdef FETCH_BUF_BYPASS_EN
  // An empty buffer hands the fetch straight to a ready Decoder without storing it.
  assign bypass = empty && fetch_vld && dec_rdy && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign push = fetch_vld && !full && !bypass;
  assign pop  = !empty && dec_rdy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (IDX_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (IDX_W + 1)'(1);
    end
  end

  fetch_buf_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata ({fetch_pc, fetch_inst}),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (rd_data)
  );

  assign fb_stall = full;
  assign fb_count = wr_ptr - rd_ptr;

  // Outputs read as zero while empty so stale or uninitialised storage never leaks out.
  always_comb begin
    dec_vld             = !empty;
    {dec_pc, dec_inst}  = empty ? '0 : rd_data;
    if (bypass) begin
      dec_vld  = 1'b1;
      dec_pc   = fetch_pc;
      dec_inst = fetch_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer; queue scoreboard tracks accepted fetches in order.
// Honours FETCH_BUF_BYPASS_EN the same way the design does.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, fetch_vld, dec_rdy;
  logic [31:0] fetch_pc, fetch_inst;
  logic        fb_stall, dec_vld;
  logic [31:0] dec_pc, dec_inst;
  logic [2:0]  fb_count;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  inst_fetch_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fetch_vld  (fetch_vld),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .fb_stall   (fb_stall),
    .dec_vld    (dec_vld),
    .dec_rdy    (dec_rdy),
    .dec_pc     (dec_pc),
    .dec_inst   (dec_inst),
    .fb_count   (fb_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  function automatic logic byp_now();
    return BYP && (sb.size() == 0) && fetch_vld && dec_rdy && !flush && !rst;
  endfunction

  function automatic logic exp_vld();
    return byp_now() || (sb.size() != 0);
  endfunction

  function automatic logic [63:0] exp_head();
    if (byp_now()) return {fetch_pc, fetch_inst};
    if (sb.size() != 0) return sb[0];
    return '0;
  endfunction

  function automatic logic [3:0] exp_cnt_stall();
    return {sb.size() == DEPTH, 3'(sb.size())};
  endfunction

  // Apply inputs just after a posedge, then move to the following negedge for sampling.
  task automatic drive_i(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
    fetch_vld  = fv;
    fetch_pc   = pc;
    fetch_inst = inst;
    dec_rdy    = rdy;
    flush      = fl;
    #4;
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic rdy, input logic fl);
    drive_i(fv, pc, inst_of(pc), rdy, fl);
  endtask

  // Update the reference queue with this cycle's handshakes, then cross the clock edge.
  task automatic tick();
    bit do_pop, do_push;
    if (rst || flush) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && dec_rdy;
      do_push = fetch_vld && (sb.size() < DEPTH) && !byp_now();
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({fetch_pc, fetch_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({dec_vld, fb_stall, fb_count} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got vld=%b stall=%b count=%0d, want 0 0 0", dec_vld, fb_stall, fb_count);
    end
    vectors++;
    if ({dec_pc, dec_inst} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: got pc=%h inst=%h, want 0 0", dec_pc, dec_inst);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      vectors++;
      if ({fb_stall, fb_count} !== exp_cnt_stall()) begin
        miscompares++;
        $display("FAIL fill_count[%0d]: got stall=%b count=%0d, want %b", i, fb_stall, fb_count, exp_cnt_stall());
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      vectors++;
      if ({fb_stall, fb_count, dec_vld, dec_pc, dec_inst} !== {1'b1, 3'd4, 1'b1, 32'h0, inst_of(32'h0)}) begin
        miscompares++;
        $display("FAIL fill_full[%0d]: got stall=%b count=%0d vld=%b pc=%h, want 1 4 1 00000000",
                 k, fb_stall, fb_count, dec_vld, dec_pc);
      end
      if (k == 0) tick();
    end
  endtask

  task automatic test_drain_wrap();
    logic [31:0] issued[$];
    logic [31:0] want[6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] pc = 32'h10;
    bit acc;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, pc, 1'b1, 1'b0);
      vectors++;
      if ({dec_vld, dec_pc, dec_inst} !== {exp_vld(), exp_head()}) begin
        miscompares++;
        $display("FAIL drain_head[%0d]: got vld=%b pc=%h inst=%h, want %b %h", c, dec_vld, dec_pc, dec_inst,
                 exp_vld(), exp_head());
      end
      if (c > 0) begin
        vectors++;
        if ({fb_stall, fb_count} !== {1'b0, 3'd3}) begin
          miscompares++;
          $display("FAIL drain_steady[%0d]: got stall=%b count=%0d, want 0 3", c, fb_stall, fb_count);
        end
      end
      if (dec_vld) issued.push_back(dec_pc);
      acc = sb.size() < DEPTH;
      tick();
      if (acc) pc += 32'h4;
    end
    vectors++;
    if (issued.size() != 6) begin
      miscompares++;
      $display("FAIL drain_issued_len: got %0d, want 6", issued.size());
    end else begin
      foreach (want[j]) begin
        vectors++;
        if (issued[j] !== want[j]) begin
          miscompares++;
          $display("FAIL drain_order[%0d]: got pc=%h, want %h", j, issued[j], want[j]);
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++;
      if ({dec_vld, dec_pc, dec_inst, fb_stall, fb_count} !== {exp_vld(), exp_head(), exp_cnt_stall()}) begin
        miscompares++;
        $display("FAIL drain_tail[%0d]: got vld=%b pc=%h count=%0d, want %b %h %b", c, dec_vld, dec_pc,
                 fb_count, exp_vld(), exp_head(), exp_cnt_stall());
      end
      tick();
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h110, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({fb_stall, fb_count, dec_vld, dec_pc} !== {1'b0, 3'd3, 1'b1, 32'h104}) begin
      miscompares++;
      $display("FAIL full_simul: got stall=%b count=%0d vld=%b pc=%h, want 0 3 1 00000104",
               fb_stall, fb_count, dec_vld, dec_pc);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    vectors++;
    if ({dec_vld, dec_pc, fb_count} !== {1'b1, 32'h30, 3'd3}) begin
      miscompares++;
      $display("FAIL flush_pre: got vld=%b pc=%h count=%0d, want 1 00000030 3", dec_vld, dec_pc, fb_count);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++;
      if ({dec_vld, fb_stall, fb_count} !== 5'b0 || dec_pc === 32'h40) begin
        miscompares++;
        $display("FAIL flush_post[%0d]: got vld=%b stall=%b count=%0d pc=%h, want 0 0 0", c, dec_vld,
                 fb_stall, fb_count, dec_pc);
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 32'h50, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h58, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if ({dec_vld, fb_stall, fb_count, dec_pc} !== 37'b0) begin
      miscompares++;
      $display("FAIL reset_midop: got vld=%b stall=%b count=%0d pc=%h, want all 0", dec_vld, fb_stall,
               fb_count, dec_pc);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_i(1'b1, 32'h20, 32'h0000_0013, 1'b1, 1'b0);
    vectors++;
    if (BYP) begin
      if ({dec_vld, dec_pc, dec_inst, fb_count} !== {1'b1, 32'h20, 32'h13, 3'd0}) begin
        miscompares++;
        $display("FAIL bypass_same: got vld=%b pc=%h inst=%h count=%0d, want 1 00000020 00000013 0",
                 dec_vld, dec_pc, dec_inst, fb_count);
      end
    end else if ({dec_vld, fb_count} !== 4'b0) begin
      miscompares++;
      $display("FAIL nobypass_same: got vld=%b count=%0d, want 0 0", dec_vld, fb_count);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (BYP) begin
      if ({dec_vld, fb_count} !== 4'b0) begin
        miscompares++;
        $display("FAIL bypass_next: got vld=%b count=%0d, want 0 0", dec_vld, fb_count);
      end
    end else if ({dec_vld, dec_pc, dec_inst, fb_count} !== {1'b1, 32'h20, 32'h13, 3'd1}) begin
      miscompares++;
      $display("FAIL nobypass_next: got vld=%b pc=%h inst=%h count=%0d, want 1 00000020 00000013 1",
               dec_vld, dec_pc, dec_inst, fb_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc = 32'h1000;
    bit acc, fv, rdy, fl;
    for (int c = 0; c < 80; c++) begin
      fv  = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      fl  = ($urandom_range(15) == 0);
      drive(fv, pc, rdy, fl);
      vectors++;
      if ({dec_vld, dec_pc, dec_inst, fb_stall, fb_count} !== {exp_vld(), exp_head(), exp_cnt_stall()}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got vld=%b pc=%h stall=%b count=%0d, want %b %h %b", c, dec_vld, dec_pc,
                 fb_stall, fb_count, exp_vld(), exp_head(), exp_cnt_stall());
      end
      acc = fv && !fl && (sb.size() < DEPTH);
      tick();
      if (acc) pc += 32'h4;
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fetch_vld = 1'b0;
    dec_rdy = 1'b0;
    fetch_pc = '0;
    fetch_inst = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_full_simul();
    test_flush();
    test_reset_midop();
    test_bypass();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
